multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter STATE_WIDTH, default 4, width of the exported state code.
REQ-002 clk  in  1  system clock; all state updates occur on its rising edge.
REQ-003 rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-004 op  in  7  instruction opcode, instr[6:0].
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7b5  in  1  instr[30].
REQ-007 Zero  in  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  PC update, memory address select (0=PC, 1=ALUOut), IR load, data write, register write.
REQ-009 ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-010 ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 (A).
REQ-011 ALUSrcB  out  2  00=rs2 (WriteData), 01=ImmExt, 10=constant 4.
REQ-012 ImmSrc  out  2  00=I, 01=S, 10=B, 11=J.
REQ-013 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-014 Illegal  out  1  sticky unsupported-opcode flag.
REQ-015 State  out  STATE_WIDTH  current state code, for debug.

Function
REQ-016 States and codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-017 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR for op 0000011 (lw) or 0100011 (sw), ->EXECR for 0110011, ->EXECI for 0010011, ->BEQ for 1100011, ->JAL for 1101111, and ->FETCH for any other op, setting Illegal.
REQ-018 Further transitions SHALL be: MEMADR->MEMREAD (lw) or ->MEMWRITE (sw); MEMREAD->MEMWB; EXECR, EXECI and JAL->ALUWB; MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-019 Outputs SHALL be a combinational (Moore) function of state, except PCWrite, and SHALL be 0 in every state unless listed in REQ-020 to REQ-027.
REQ-020 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target).
REQ-022 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
REQ-023 MEMREAD: ResultSrc=00, AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1. MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-024 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. ALUWB: ResultSrc=00, RegWrite=1.
REQ-025 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, PCWrite=Zero (same-cycle combinational).
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCWrite=1.
REQ-027 ImmSrc SHALL decode from op in every state: lw/I-ALU=00, sw=01, beq=10, jal=11, others=00.
REQ-028 ALUOp=funct SHALL decode funct3 as follows: 000 gives sub if op[5]&funct7b5, else add; 010 gives slt; 110 gives or; 111 gives and; any other funct3 gives add.
REQ-029 Cycle counts per instruction SHALL be: lw=5, sw=4, R/I=4, beq=3, jal=4, unsupported=2.

Reset
REQ-030 rst high at a rising edge SHALL set State=FETCH and Illegal=0, taking priority over any transition, including mid-instruction.
REQ-031 While rst is high, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0.
REQ-032 The first cycle after rst deasserts SHALL be FETCH with FETCH outputs.

Verification
REQ-033 Reset, then op=0000011 held -> State 0,1,2,3,4,0; RegWrite=1 only in state 4, with ResultSrc=01.
REQ-034 op=0100011 -> State 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in state 5; RegWrite never 1.
REQ-035 op=0110011, funct3=000, funct7b5=1 -> in EXECR ALUControl=001; the same with funct7b5=0 -> 000; op=0010011, funct3=000, funct7b5=1 -> 000.
REQ-036 op=1100011 in BEQ: Zero=1 -> PCWrite=1; Zero=0 -> PCWrite=0; next state FETCH either way.
REQ-037 op=0000000 -> State 0,1,0; Illegal becomes 1 after DECODE and stays 1 until rst.
REQ-038 rst asserted while in MEMWB -> next State=0, RegWrite=0 during the reset cycle, Illegal=0.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle RISC-V subset core (lw, sw, R-type ALU,
// I-type ALU, beq, jal). It sequences each instruction through
// fetch/decode/execute/writeback states and drives the datapath selects.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   op           instr[6:0] opcode
//   funct3       instr[14:12]
//   funct7b5     instr[30], selects sub versus add for R-type
//   Zero         ALU zero flag, gates the branch PC update
//   PCWrite      PC load enable
//   AdrSrc       memory address select (0 = PC, 1 = ALUOut)
//   IRWrite      instruction register load enable
//   MemWrite     data memory write enable
//   RegWrite     register file write enable
//   ResultSrc    result select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA      ALU A select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB      ALU B select (00 rs2, 01 ImmExt, 10 constant 4)
//   ImmSrc       immediate format (00 I, 01 S, 10 B, 11 J)
//   ALUControl   ALU function (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   Illegal      sticky flag, set when an unsupported opcode is decoded
//   State        current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter int STATE_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [6:0]             op,
   input  logic [2:0]             funct3,
   input  logic                   funct7b5,
   input  logic                   Zero,
   output logic                   PCWrite,
   output logic                   AdrSrc,
   output logic                   IRWrite,
   output logic                   MemWrite,
   output logic                   RegWrite,
   output logic [1:0]             ResultSrc,
   output logic [1:0]             ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [1:0]             ImmSrc,
   output logic [2:0]             ALUControl,
   output logic                   Illegal,
   output logic [STATE_WIDTH-1:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } alu_op_e;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_ITYP = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_e  state_q, state_d;
   logic    illegal_q, illegal_d;
   alu_op_e alu_op;
   logic    pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw;

   // State and sticky illegal flag; reset wins over any pending transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic. Unused codes fall into the default and recover to FETCH.
   always_comb begin
      state_d   = S_FETCH;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYP:      state_d = S_EXECR;
               OP_ITYP:      state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI,
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore outputs per state. PCWrite in BEQ is the only input-dependent term.
   always_comb begin
      pc_write_raw  = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      mem_write_raw = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      alu_op        = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            pc_write_raw = 1'b1;
            ALUSrcB      = 2'b10;
            ResultSrc    = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc     = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA      = 2'b10;
            alu_op       = ALUOP_SUB;
            pc_write_raw = Zero;
         end
         S_JAL: begin
            ALUSrcA      = 2'b01;
            ALUSrcB      = 2'b10;
            pc_write_raw = 1'b1;
         end
         default: begin
            pc_write_raw = 1'b0;
         end
      endcase
   end

   // ALU decoder. Subtract only for R-type (op[5]) with funct7b5 set, so
   // addi with a negative immediate whose bit 30 is 1 still adds.
   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         ALUOP_SUB: ALUControl = 3'b001;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   // Immediate format is decoded from the opcode regardless of state.
   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Write enables are masked while reset is held so no architectural state
   // is disturbed during the reset cycle.
   assign PCWrite  = pc_write_raw  & ~rst;
   assign IRWrite  = ir_write_raw  & ~rst;
   assign RegWrite = reg_write_raw & ~rst;
   assign MemWrite = mem_write_raw & ~rst;
   assign Illegal  = illegal_q;
   assign State    = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control: walks each supported instruction
// class through its state sequence, checks the key control outputs per
// state, then exercises the illegal-opcode flag and a mid-instruction reset.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   logic       clk;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic       Illegal;
   logic [3:0] State;

   int checks   = 0;
   int failures = 0;

   multicycle_control #(.STATE_WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal),
      .State      (State)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still reports and terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [6:0] o,
                                input logic [2:0] f3, input logic f7,
                                input logic z);
      rst      = r;
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      Zero     = z;
   endtask

   // Advance to the next falling edge and check the state reached.
   task automatic stepExpect(input string tag, input logic [3:0] s);
      @(negedge clk);
      checkOutput(tag, {28'd0, State}, {28'd0, s});
   endtask

   initial begin
      // Reset held for two edges; write enables must be masked.
      applyStimulus(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_state",    {28'd0, State}, 32'd0);
      checkOutput("rst_illegal",  {31'd0, Illegal}, 32'd0);
      checkOutput("rst_pcwrite",  {31'd0, PCWrite}, 32'd0);
      checkOutput("rst_irwrite",  {31'd0, IRWrite}, 32'd0);

      // First cycle after reset: FETCH outputs visible.
      rst = 1'b0;
      #1;
      checkOutput("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
      checkOutput("fetch_pcwrite", {31'd0, PCWrite}, 32'd1);
      checkOutput("fetch_srcb",    {30'd0, ALUSrcB}, 32'd2);
      checkOutput("fetch_result",  {30'd0, ResultSrc}, 32'd2);
      checkOutput("lw_immsrc",     {30'd0, ImmSrc}, 32'd0);

      // lw: 0,1,2,3,4,0
      stepExpect("lw_s1", 4'd1);
      checkOutput("decode_srca", {30'd0, ALUSrcA}, 32'd1);
      checkOutput("decode_srcb", {30'd0, ALUSrcB}, 32'd1);
      checkOutput("lw_regw_s1",  {31'd0, RegWrite}, 32'd0);
      stepExpect("lw_s2", 4'd2);
      checkOutput("memadr_srca", {30'd0, ALUSrcA}, 32'd2);
      checkOutput("lw_regw_s2",  {31'd0, RegWrite}, 32'd0);
      stepExpect("lw_s3", 4'd3);
      checkOutput("memread_adr", {31'd0, AdrSrc}, 32'd1);
      checkOutput("lw_regw_s3",  {31'd0, RegWrite}, 32'd0);
      stepExpect("lw_s4", 4'd4);
      checkOutput("lw_regw_s4",  {31'd0, RegWrite}, 32'd1);
      checkOutput("lw_result",   {30'd0, ResultSrc}, 32'd1);
      stepExpect("lw_s0", 4'd0);
      checkOutput("lw_regw_s0",  {31'd0, RegWrite}, 32'd0);

      // sw: 0,1,2,5,0
      applyStimulus(1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0);
      #1;
      checkOutput("sw_immsrc", {30'd0, ImmSrc}, 32'd1);
      stepExpect("sw_s1", 4'd1);
      checkOutput("sw_memw_s1", {31'd0, MemWrite}, 32'd0);
      stepExpect("sw_s2", 4'd2);
      checkOutput("sw_adr_s2",  {31'd0, AdrSrc}, 32'd0);
      stepExpect("sw_s5", 4'd5);
      checkOutput("sw_memw_s5", {31'd0, MemWrite}, 32'd1);
      checkOutput("sw_adr_s5",  {31'd0, AdrSrc}, 32'd1);
      checkOutput("sw_regw_s5", {31'd0, RegWrite}, 32'd0);
      stepExpect("sw_s0", 4'd0);
      checkOutput("sw_memw_s0", {31'd0, MemWrite}, 32'd0);

      // R-type sub: 0,1,6,8,0
      applyStimulus(1'b0, 7'b0110011, 3'b000, 1'b1, 1'b0);
      stepExpect("rsub_s1", 4'd1);
      stepExpect("rsub_s6", 4'd6);
      checkOutput("rsub_aluctl", {29'd0, ALUControl}, 32'd1);
      checkOutput("execr_srca",  {30'd0, ALUSrcA}, 32'd2);
      checkOutput("execr_srcb",  {30'd0, ALUSrcB}, 32'd0);
      stepExpect("rsub_s8", 4'd8);
      checkOutput("aluwb_regw",  {31'd0, RegWrite}, 32'd1);
      checkOutput("aluwb_result", {30'd0, ResultSrc}, 32'd0);
      stepExpect("rsub_s0", 4'd0);

      // R-type add
      applyStimulus(1'b0, 7'b0110011, 3'b000, 1'b0, 1'b0);
      stepExpect("radd_s1", 4'd1);
      stepExpect("radd_s6", 4'd6);
      checkOutput("radd_aluctl", {29'd0, ALUControl}, 32'd0);
      // Other funct3 decodes checked combinationally in EXECR.
      funct3 = 3'b111;
      #1;
      checkOutput("rand_aluctl", {29'd0, ALUControl}, 32'd2);
      funct3 = 3'b110;
      #1;
      checkOutput("ror_aluctl",  {29'd0, ALUControl}, 32'd3);
      funct3 = 3'b010;
      #1;
      checkOutput("rslt_aluctl", {29'd0, ALUControl}, 32'd5);
      funct3 = 3'b001;
      #1;
      checkOutput("rsll_aluctl", {29'd0, ALUControl}, 32'd0);
      stepExpect("radd_s8", 4'd8);
      stepExpect("radd_s0", 4'd0);

      // I-type addi with bit30 set still adds.
      applyStimulus(1'b0, 7'b0010011, 3'b000, 1'b1, 1'b0);
      stepExpect("addi_s1", 4'd1);
      stepExpect("addi_s7", 4'd7);
      checkOutput("addi_aluctl", {29'd0, ALUControl}, 32'd0);
      checkOutput("execi_srcb",  {30'd0, ALUSrcB}, 32'd1);
      stepExpect("addi_s8", 4'd8);
      stepExpect("addi_s0", 4'd0);

      // beq: PCWrite follows Zero combinationally, then FETCH.
      applyStimulus(1'b0, 7'b1100011, 3'b000, 1'b0, 1'b1);
      stepExpect("beq_s1", 4'd1);
      checkOutput("beq_immsrc", {30'd0, ImmSrc}, 32'd2);
      stepExpect("beq_s9", 4'd9);
      checkOutput("beq_pcw_z1", {31'd0, PCWrite}, 32'd1);
      checkOutput("beq_aluctl", {29'd0, ALUControl}, 32'd1);
      Zero = 1'b0;
      #1;
      checkOutput("beq_pcw_z0", {31'd0, PCWrite}, 32'd0);
      stepExpect("beq_s0", 4'd0);

      // jal: 0,1,10,8,0
      applyStimulus(1'b0, 7'b1101111, 3'b000, 1'b0, 1'b0);
      stepExpect("jal_s1", 4'd1);
      checkOutput("jal_immsrc", {30'd0, ImmSrc}, 32'd3);
      stepExpect("jal_s10", 4'd10);
      checkOutput("jal_pcw",  {31'd0, PCWrite}, 32'd1);
      checkOutput("jal_srca", {30'd0, ALUSrcA}, 32'd1);
      checkOutput("jal_srcb", {30'd0, ALUSrcB}, 32'd2);
      stepExpect("jal_s8", 4'd8);
      stepExpect("jal_s0", 4'd0);

      // Unsupported opcode: 0,1,0 and sticky Illegal.
      applyStimulus(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b0);
      stepExpect("ill_s1", 4'd1);
      checkOutput("ill_before", {31'd0, Illegal}, 32'd0);
      stepExpect("ill_s0", 4'd0);
      checkOutput("ill_set",    {31'd0, Illegal}, 32'd1);

      // lw to MEMWB with Illegal still set, then reset mid-instruction.
      applyStimulus(1'b0, 7'b0000011, 3'b000, 1'b0, 1'b0);
      stepExpect("lw2_s1", 4'd1);
      stepExpect("lw2_s2", 4'd2);
      stepExpect("lw2_s3", 4'd3);
      stepExpect("lw2_s4", 4'd4);
      checkOutput("ill_sticky", {31'd0, Illegal}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("rstwb_regw", {31'd0, RegWrite}, 32'd0);
      stepExpect("rstwb_s0", 4'd0);
      checkOutput("rstwb_illegal", {31'd0, Illegal}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_irwrite", {31'd0, IRWrite}, 32'd1);
      stepExpect("post_s1", 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
